// File: rtl/fp_add_stream_adapter.sv
// Streaming wrapper around a fixed-latency FloPoCo adder: tracks in-flight operations,
// buffers results in a first-word-fall-through FIFO and issues input credits so the buffer never overflows.
module fp_add_stream_adapter #(
    parameter int LATENCY    = 7,
    parameter int FIFO_DEPTH = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [33:0] in_x,
    input  logic [33:0] in_y,
    output logic        core_ce,
    output logic [33:0] core_x,
    output logic [33:0] core_y,
    input  logic [33:0] core_r,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [33:0] out_data,
    output logic [15:0] nan_count
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

    logic [LATENCY-1:0] vld_q, vld_d;
    logic [CW-1:0]      credit_q, credit_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [15:0]        nan_q, nan_d;
    logic [33:0]        mem_q [FIFO_DEPTH];

    logic accept_s;
    logic wr_s;
    logic pop_s;
    logic is_nan_s;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    assign core_x    = in_x;
    assign core_y    = in_y;
    assign core_ce   = rst_n;
    assign in_ready  = rst_n & (credit_q != {CW{1'b0}});
    assign out_valid = (cnt_q != {CW{1'b0}});
    // Gating by count keeps stale memory contents (e.g. from before a reset) off the output.
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : 34'h0;
    assign nan_count = nan_q;

    assign accept_s = in_valid & in_ready;
    assign wr_s     = vld_q[LATENCY-1];
    assign pop_s    = out_valid & out_ready;
    assign is_nan_s = (core_r[33:32] == 2'b11);

    // Next-state logic for the valid pipe, credits, occupancy, pointers and NaN counter.
    always_comb begin
        vld_d    = (vld_q << 1) | LATENCY'(accept_s);
        credit_d = credit_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        nan_d    = nan_q;

        case ({accept_s, pop_s})
            2'b10:   credit_d = credit_q - CW'(1);
            2'b01:   credit_d = credit_q + CW'(1);
            default: credit_d = credit_q;
        endcase

        case ({wr_s, pop_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        if (wr_s) begin
            wr_ptr_d = ptr_next(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        if (wr_s && is_nan_s && (nan_q != 16'hFFFF)) begin
            nan_d = nan_q + 16'd1;
        end else begin
            nan_d = nan_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q    <= {LATENCY{1'b0}};
            credit_q <= DEPTH_C;
            cnt_q    <= {CW{1'b0}};
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            nan_q    <= 16'h0000;
        end else begin
            vld_q    <= vld_d;
            credit_q <= credit_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            nan_q    <= nan_d;
        end
    end

    // Result storage; contents only become visible through a valid count.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_q[wr_ptr_q] <= core_r;
        end
    end

endmodule

// File: tb/tb_fp_add_stream_adapter.sv
// Scoreboard bench: a mock fixed-latency adder core, an in-order expected-result queue
// filled on every accept, and an independent monitor that compares every pop.
module tb_fp_add_stream_adapter;

    localparam int LAT   = 7;
    localparam int DEPTH = 9;
    localparam logic [33:0] ONE   = 34'h1_3F80_0000;
    localparam logic [33:0] TWO   = 34'h1_4000_0000;
    localparam logic [33:0] THREE = 34'h1_4040_0000;
    localparam logic [33:0] QNAN  = 34'h3_7FC0_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [33:0] in_x, in_y;
    logic        core_ce;
    logic [33:0] core_x, core_y, core_r;
    logic        out_valid;
    logic        out_ready;
    logic [33:0] out_data;
    logic [15:0] nan_count;

    int n_cmp  = 0;
    int n_fail = 0;
    int stalls = 0;
    int cyc    = 0;
    int ref_nan = 0;
    logic [33:0] sb_q[$];
    int  pop_cyc_q[$];
    bit  prev_stall = 1'b0;
    logic [33:0] prev_data;

    fp_add_stream_adapter #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .core_ce(core_ce), .core_x(core_x), .core_y(core_y),
        .core_r(core_r), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .nan_count(nan_count)
    );

    always #5 clk = ~clk;

    // Stand-in adder: NaN propagation, exact 1.0+2.0, otherwise an opaque mix.
    function automatic logic [33:0] mock_add(input logic [33:0] x, input logic [33:0] y);
        if (x[33:32] == 2'b11 || y[33:32] == 2'b11) return QNAN;
        if (x == ONE && y == TWO) return THREE;
        return {2'b01, x[31:0] + y[31:0]};
    endfunction

    function automatic logic [33:0] rand_op(input bit allow_nan);
        logic [1:0] e;
        e = allow_nan ? 2'($urandom_range(0, 3)) : 2'b01;
        return {e, 32'($urandom)};
    endfunction

    logic [33:0] pipe [LAT];
    assign core_r = pipe[LAT-1];
    always @(posedge clk) begin
        if (core_ce) begin
            pipe[0] <= mock_add(core_x, core_y);
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: every observed accept yields one result, in order.
    always @(negedge clk) begin
        if (!rst_n) begin
            ref_nan = 0;
        end else if (in_valid && in_ready) begin
            sb_q.push_back(mock_add(in_x, in_y));
            if (mock_add(in_x, in_y) == QNAN && ref_nan < 65535) ref_nan++;
        end
    end

    // Monitor: compare each pop against the queue head and check hold-under-stall.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && out_valid) check("hold_stable", 64'(out_data), 64'(prev_data));
            if (out_valid && out_ready) begin
                pop_cyc_q.push_back(cyc);
                if (sb_q.size() == 0) check("unexpected_pop", 64'(out_data), 64'h0);
                else check("pop_data", 64'(out_data), 64'(sb_q.pop_front()));
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a pair and return just after the edge that accepted it (in_valid left high).
    task automatic send(input logic [33:0] x, input logic [33:0] y);
        bit done = 1'b0;
        int tries = 0;
        in_valid = 1'b1;
        in_x = x;
        in_y = y;
        while (!done) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            else stalls++;
            step();
            tries++;
            if (!done && tries > 500) begin
                check("send_timeout", 64'd0, 64'd1);
                done = 1'b1;
            end
        end
    endtask

    task automatic drain();
        bit done = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !out_valid) done = 1'b1;
        end
        if (!done) check("drain_timeout", 64'(sb_q.size()), 64'd0);
        step();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_x = '0; in_y = '0;
        repeat (3) step();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_core_ce", 64'(core_ce), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_nan_count", 64'(nan_count), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_core_ce", 64'(core_ce), 64'd1);
        in_x = rand_op(1'b1); in_y = rand_op(1'b1);
        #1;
        check("core_x_pass", 64'(core_x), 64'(in_x));
        check("core_y_pass", 64'(core_y), 64'(in_y));
        step();

        // Single operation: result visible LAT edges after the accept edge, for one cycle.
        out_ready = 1'b1;
        send(ONE, TWO);
        in_valid = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            if (i == LAT - 1) check("single_early", 64'(out_valid), 64'd0);
        end
        @(negedge clk);
        check("single_valid", 64'(out_valid), 64'd1);
        check("single_data", 64'(out_data), 64'(THREE));
        @(negedge clk);
        check("single_done", 64'(out_valid), 64'd0);
        step();

        // Back-to-back streaming with the consumer always ready.
        stalls = 0;
        p0 = pop_cyc_q.size();
        for (int i = 0; i < 100; i++) send(rand_op(1'b0), rand_op(1'b0));
        drain();
        check("stream_stalls", 64'(stalls), 64'd0);
        check("stream_count", 64'(pop_cyc_q.size() - p0), 64'd100);
        if (pop_cyc_q.size() - p0 == 100)
            check("stream_rate", 64'(pop_cyc_q[p0 + 99] - pop_cyc_q[p0]), 64'd99);

        // Back-pressure: fill all credits, then free one.
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) send(rand_op(1'b0), rand_op(1'b0));
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        step();
        repeat (LAT + 3) step();
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_still_blocked", 64'(in_ready), 64'd0);
        check("bp_sb_full", 64'(sb_q.size()), 64'(DEPTH));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_in_ready_back", 64'(in_ready), 64'd1);
        step();

        // Random traffic near full and near empty exercises simultaneous write/pop and wrap.
        for (int i = 0; i < 800; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_x      = rand_op(1'b1);
            in_y      = rand_op(1'b1);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();
        check("rand_nan_count", 64'(nan_count), 64'(ref_nan));

        // Reset mid-flight: three buffered, four in the pipe.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(rand_op(1'b0), rand_op(1'b0));
        in_valid = 1'b0;
        repeat (LAT + 2) step();
        for (int i = 0; i < 4; i++) send(rand_op(1'b0), rand_op(1'b0));
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_out_data", 64'(out_data), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        repeat (2) step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        p0 = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) p0++;
        end
        check("post_rst_silent", 64'(p0), 64'd0);
        check("post_rst_nan", 64'(nan_count), 64'd0);
        step();
        send(ONE, TWO);
        drain();

        // NaN counting and saturation.
        send({2'b11, 32'($urandom)}, rand_op(1'b0));
        for (int i = 0; i < 5; i++) send(rand_op(1'b0), rand_op(1'b0));
        drain();
        check("nan_one", 64'(nan_count), 64'd1);
        for (int i = 0; i < 65533; i++) send({2'b11, 32'($urandom)}, rand_op(1'b1));
        drain();
        check("nan_fffe", 64'(nan_count), 64'hFFFE);
        for (int i = 0; i < 3; i++) send(rand_op(1'b1), {2'b11, 32'($urandom)});
        drain();
        check("nan_sat", 64'(nan_count), 64'hFFFF);
        check("nan_model", 64'(nan_count), 64'(ref_nan));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
